// File: rtl/debounce_filter_if.sv
// Signal bundle between a raw-input source and the debounce filter.
// sample_en/signal_in flow into the filter; signal_out/settling flow back out.
interface debounce_filter_if #(
  parameter int WIDTH = 1
);
  logic             sample_en;
  logic [WIDTH-1:0] signal_in;
  logic [WIDTH-1:0] signal_out;
  logic [WIDTH-1:0] settling;

  modport master (
    output sample_en,
    output signal_in,
    input  signal_out,
    input  settling
  );

  modport slave (
    input  sample_en,
    input  signal_in,
    output signal_out,
    output settling
  );
endinterface

// File: rtl/debounce_filter.sv
// Per-bit 2-flop synchronizer followed by a stability counter FSM; a bit's output
// flips only after sync2 disagrees with it for STABLE_CYCLES consecutive qualified samples.
module debounce_filter #(
  parameter int               WIDTH         = 1,
  parameter int               STABLE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic              clk,
  input  logic              n_rst,
  debounce_filter_if.slave  bus
);

  localparam int            CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] w_mismatch;
  logic [WIDTH-1:0] w_settling;
  state_t           r_state     [WIDTH];
  state_t           w_state_nxt [WIDTH];
  logic [CW-1:0]    r_cnt       [WIDTH];
  logic [CW-1:0]    w_cnt_nxt   [WIDTH];

  assign w_mismatch = r_sync2 ^ r_out;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= RESET_VALUE;
      r_sync2 <= RESET_VALUE;
      r_out   <= RESET_VALUE;
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= ST_STABLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_sync1 <= bus.signal_in;
      r_sync2 <= r_sync1;
      r_out   <= w_out_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // A bounce (sync2 agreeing with the output again) aborts a count even when
  // sample_en is low; only the advance of the counter is qualified.
  always_comb begin
    w_out_nxt = r_out;
    for (int i = 0; i < WIDTH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_STABLE: begin
          if (w_mismatch[i] && bus.sample_en) begin
            w_state_nxt[i] = ST_SETTLING;
            w_cnt_nxt[i]   = CW'(1);
          end
        end
        ST_SETTLING: begin
          if (!w_mismatch[i]) begin
            w_state_nxt[i] = ST_STABLE;
            w_cnt_nxt[i]   = '0;
          end else if (bus.sample_en) begin
            if (r_cnt[i] == CNT_LAST) begin
              w_out_nxt[i]   = r_sync2[i];
              w_state_nxt[i] = ST_STABLE;
              w_cnt_nxt[i]   = '0;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
          end
        end
        default: begin
          w_state_nxt[i] = ST_STABLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_settling = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_settling[i] = (r_state[i] == ST_SETTLING);
    end
  end

  assign bus.signal_out = r_out;
  assign bus.settling   = w_settling;

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench: a 4-bit/4-cycle instance for step, bounce, gating, mid-settle reset
// and bit independence; a 1-bit/16-cycle instance for reset-release latency.
module tb_debounce_filter;

  logic clk;
  logic n_rst_a;
  logic n_rst_b;

  int n_checks;
  int n_pass;
  int n_fail;

  debounce_filter_if #(.WIDTH(4)) if_a ();
  debounce_filter_if #(.WIDTH(1)) if_b ();

  debounce_filter #(
    .WIDTH         (4),
    .STABLE_CYCLES (4),
    .RESET_VALUE   (4'b0000)
  ) u_dut_a (
    .clk   (clk),
    .n_rst (n_rst_a),
    .bus   (if_a)
  );

  debounce_filter #(
    .WIDTH         (1),
    .STABLE_CYCLES (16),
    .RESET_VALUE   (1'b0)
  ) u_dut_b (
    .clk   (clk),
    .n_rst (n_rst_b),
    .bus   (if_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream edge detector on bit 0 of instance A
  logic r_prev0;
  int   pos_cnt;
  always_ff @(posedge clk) begin
    if (!n_rst_a) begin
      r_prev0 <= 1'b0;
      pos_cnt <= 0;
    end else begin
      r_prev0 <= if_a.signal_out[0];
      if (if_a.signal_out[0] && !r_prev0) pos_cnt <= pos_cnt + 1;
    end
  end

  // driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] ev_out;
  logic [3:0] ev_set;
  int         pos_before;
  logic [3:0] bounce_vals [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    n_rst_a  = 1'b0;
    n_rst_b  = 1'b0;
    if_a.sample_en = 1'b1;
    if_a.signal_in = 4'b0000;
    if_b.sample_en = 1'b1;
    if_b.signal_in = 1'b1;
    bounce_vals[0] = 4'b0001;
    bounce_vals[1] = 4'b0000;
    bounce_vals[2] = 4'b0001;
    bounce_vals[3] = 4'b0000;

    // reset state, with B's raw input already high
    repeat (3) step();
    check("rst_a_out", 32'(if_a.signal_out), 32'h0);
    check("rst_a_settling", 32'(if_a.settling), 32'h0);
    check("rst_b_out", 32'(if_b.signal_out), 32'h0);
    check("rst_b_settling", 32'(if_b.settling), 32'h0);

    // release: B must take the normal path, output at the 18th edge
    n_rst_a = 1'b1;
    n_rst_b = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      step();
      if (e == 2)  check("rel_b_settling_e2", 32'(if_b.settling), 32'h0);
      if (e == 3)  check("rel_b_settling_e3", 32'(if_b.settling), 32'h1);
      if (e == 17) begin
        check("rel_b_out_e17", 32'(if_b.signal_out), 32'h0);
        check("rel_b_settling_e17", 32'(if_b.settling), 32'h1);
      end
      if (e == 18) begin
        check("rel_b_out_e18", 32'(if_b.signal_out), 32'h1);
        check("rel_b_settling_e18", 32'(if_b.settling), 32'h0);
      end
    end

    // clean rising step on bit 0 before edge k=0
    if_a.signal_in = 4'b0001;
    for (int e = 0; e <= 5; e++) begin
      step();
      ev_out = (e >= 5) ? 4'b0001 : 4'b0000;
      ev_set = (e >= 2 && e <= 4) ? 4'b0001 : 4'b0000;
      check($sformatf("step_rise_out_e%0d", e), 32'(if_a.signal_out), 32'(ev_out));
      check($sformatf("step_rise_set_e%0d", e), 32'(if_a.settling), 32'(ev_set));
    end

    // clean falling step
    if_a.signal_in = 4'b0000;
    for (int e = 0; e <= 5; e++) begin
      step();
      ev_out = (e >= 5) ? 4'b0000 : 4'b0001;
      ev_set = (e >= 2 && e <= 4) ? 4'b0001 : 4'b0000;
      check($sformatf("step_fall_out_e%0d", e), 32'(if_a.signal_out), 32'(ev_out));
      check($sformatf("step_fall_set_e%0d", e), 32'(if_a.settling), 32'(ev_set));
    end

    // bounce 1,0,1,0 with 2-cycle dwell, then final 1 held
    pos_before = pos_cnt;
    for (int b = 0; b < 4; b++) begin
      if_a.signal_in = bounce_vals[b];
      repeat (2) begin
        step();
        check($sformatf("bounce_out_b%0d", b), 32'(if_a.signal_out), 32'h0);
      end
    end
    if_a.signal_in = 4'b0001;
    for (int e = 0; e <= 5; e++) begin
      step();
      ev_out = (e >= 5) ? 4'b0001 : 4'b0000;
      check($sformatf("bounce_final_out_e%0d", e), 32'(if_a.signal_out), 32'(ev_out));
    end
    repeat (2) step();
    check("bounce_pos_edges", 32'(pos_cnt - pos_before), 32'd1);

    // gated sampling: tick every 3rd clock, input steps to 0 before edge t=0
    for (int t = 0; t <= 13; t++) begin
      if_a.sample_en = (t % 3 == 0);
      if (t == 0) if_a.signal_in = 4'b0000;
      step();
      ev_out = (t >= 12) ? 4'b0000 : 4'b0001;
      ev_set = (t >= 3 && t < 12) ? 4'b0001 : 4'b0000;
      check($sformatf("gated_out_t%0d", t), 32'(if_a.signal_out), 32'(ev_out));
      check($sformatf("gated_set_t%0d", t), 32'(if_a.settling), 32'(ev_set));
    end

    // gated rise with a one-clock glitch landing between ticks
    for (int t = 0; t <= 19; t++) begin
      if_a.sample_en = (t % 3 == 0);
      if_a.signal_in = (t == 6) ? 4'b0000 : 4'b0001;
      step();
      ev_out = (t >= 18) ? 4'b0001 : 4'b0000;
      ev_set = ((t >= 3 && t <= 7) || (t >= 9 && t <= 17)) ? 4'b0001 : 4'b0000;
      check($sformatf("glitch_out_t%0d", t), 32'(if_a.signal_out), 32'(ev_out));
      check($sformatf("glitch_set_t%0d", t), 32'(if_a.settling), 32'(ev_set));
    end
    if_a.sample_en = 1'b1;

    // mid-settle reset with counter at 2
    if_a.signal_in = 4'b0000;
    repeat (4) step();
    check("mid_pre_out", 32'(if_a.signal_out), 32'h1);
    check("mid_pre_set", 32'(if_a.settling), 32'h1);
    n_rst_a = 1'b0;
    #1;
    check("mid_async_out", 32'(if_a.signal_out), 32'h0);
    check("mid_async_set", 32'(if_a.settling), 32'h0);
    if_a.signal_in = 4'b0001;
    repeat (2) step();
    check("mid_hold_out", 32'(if_a.signal_out), 32'h0);
    n_rst_a = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      ev_out = (e >= 6) ? 4'b0001 : 4'b0000;
      ev_set = (e >= 3 && e <= 5) ? 4'b0001 : 4'b0000;
      check($sformatf("mid_rel_out_e%0d", e), 32'(if_a.signal_out), 32'(ev_out));
      check($sformatf("mid_rel_set_e%0d", e), 32'(if_a.settling), 32'(ev_set));
    end

    // multi-bit: bit0 falls clean, bit2 bounces 1,0,1, bits 1/3 static
    for (int t = 0; t <= 10; t++) begin
      if_a.signal_in = {1'b0, ((t < 2) || (t >= 4)), 1'b0, 1'b0};
      step();
      ev_out = {1'b0, (t >= 9), 1'b0, (t < 5)};
      ev_set = {1'b0, (t == 2 || t == 3 || t == 6 || t == 7 || t == 8),
                1'b0, (t >= 2 && t <= 4)};
      check($sformatf("multi_out_t%0d", t), 32'(if_a.signal_out), 32'(ev_out));
      check($sformatf("multi_set_t%0d", t), 32'(if_a.settling), 32'(ev_set));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
